// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad entry sequencer.
//   state_t    - sequencer FSM states
//   MAX_DIGITS - capacity of the MM:SS entry register
//   BCD_W      - width of one BCD digit
//   KEY_W      - number of raw key lines (digits 0..9)
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam int unsigned MAX_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned KEY_W      = 10;

endpackage

// File: rtl/keypad_entry_ctrl_key_onehot_bcd.sv
// key_onehot_bcd: combinational key-vector to BCD encoder.
//   keys   in  KEY_W  key vector, bit n = digit n
//   bcd    out BCD_W  digit index when keys is one-hot, else 0
//   onehot out 1      high when exactly one key bit is set
// Multi-hot or all-zero vectors are not priority-encoded; they report onehot = 0.
module key_onehot_bcd
    import keypad_pkg::*;
(
    input  logic [KEY_W-1:0] keys,
    output logic [BCD_W-1:0] bcd,
    output logic             onehot
);

    always_comb begin
        bcd    = '0;
        onehot = 1'b0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (keys == (KEY_W'(1) << i)) begin
                bcd    = BCD_W'(i);
                onehot = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: 10-key keypad sequencer feeding the MM:SS time entry.
// Synchronises and debounces the raw key lines, encodes each accepted press to
// BCD and shifts it into a 4-digit entry register, once per physical press.
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   KEYS       in   raw one-hot key lines (asynchronous)
//   LOCK       in   high while cooking: no new press is started
//   CLEAR      in   synchronous clear of digits and digit count
//   MIN_TENS.. out  BCD entry digits 3..0 (SEC_ONES = most recent key)
//   DIGIT_CNT  out  number of digits entered, 0..4
//   KEY_STROBE out  one-cycle pulse when the entry register takes a digit
//   ERR        out  one-cycle pulse on a multi-key press
// Build option: define MULTI_KEY_ERR_EN to drive ERR; otherwise ERR is tied 0.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [KEY_W-1:0] KEYS,
    input  logic             LOCK,
    input  logic             CLEAR,
    output logic [BCD_W-1:0] MIN_TENS,
    output logic [BCD_W-1:0] MIN_ONES,
    output logic [BCD_W-1:0] SEC_TENS,
    output logic [BCD_W-1:0] SEC_ONES,
    output logic [2:0]       DIGIT_CNT,
    output logic             KEY_STROBE,
    output logic             ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [2:0]       DIGITS_FULL = 3'(MAX_DIGITS);

    logic [KEY_W-1:0] sync1, sync_s;
    logic [KEY_W-1:0] cand, cand_nxt;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [MAX_DIGITS-1:0][BCD_W-1:0] digits;
    logic [2:0]       digit_cnt;
    logic [BCD_W-1:0] cand_bcd;
    logic             cand_onehot;
    logic             do_shift;

    key_onehot_bcd u_enc (
        .keys   (cand),
        .bcd    (cand_bcd),
        .onehot (cand_onehot)
    );

    // Bits of the key vector may resolve on different cycles through the
    // synchroniser; the debounce run absorbs that skew.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        do_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync_s != '0 && !LOCK) begin
                    state_nxt = ST_DEBOUNCE;
                    cand_nxt  = sync_s;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (sync_s == cand) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_LAST) begin
                        state_nxt = ST_CAPTURE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_WAIT_REL;
                cnt_nxt   = '0;
                do_shift  = cand_onehot && (digit_cnt < DIGITS_FULL) && !CLEAR;
            end
            ST_WAIT_REL: begin
                if (sync_s == '0) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_LAST) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1  <= '0;
            sync_s <= '0;
            cand   <= '0;
            state  <= ST_IDLE;
            cnt    <= '0;
        end else begin
            sync1  <= KEYS;
            sync_s <= sync1;
            cand   <= cand_nxt;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // CLEAR has priority over a capture landing on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digits     <= '0;
            digit_cnt  <= '0;
            KEY_STROBE <= 1'b0;
        end else begin
            KEY_STROBE <= do_shift;
            if (CLEAR) begin
                digits    <= '0;
                digit_cnt <= '0;
            end else if (do_shift) begin
                digits    <= {digits[MAX_DIGITS-2:0], cand_bcd};
                digit_cnt <= digit_cnt + 3'd1;
            end
        end
    end

`ifdef MULTI_KEY_ERR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR <= 1'b0;
        end else begin
            ERR <= (state == ST_CAPTURE) && !cand_onehot;
        end
    end
`else
    assign ERR = 1'b0;
`endif

    assign MIN_TENS  = digits[3];
    assign MIN_ONES  = digits[2];
    assign SEC_TENS  = digits[1];
    assign SEC_ONES  = digits[0];
    assign DIGIT_CNT = digit_cnt;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl with DEBOUNCE_CYCLES = 4. Every cycle the DUT is
// compared against a behavioural model of the keypad rules; a vector table and
// a few hand-written sequences add checks against fixed expected values.
module tb_keypad_entry_ctrl;

    localparam int N = 4;
`ifdef MULTI_KEY_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, lock, clear;
    logic [9:0] keys;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] digit_cnt;
    logic       key_strobe, err;

    always #5 clk = ~clk;

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .CLK        (clk),
        .RST        (rst),
        .KEYS       (keys),
        .LOCK       (lock),
        .CLEAR      (clear),
        .MIN_TENS   (min_tens),
        .MIN_ONES   (min_ones),
        .SEC_TENS   (sec_tens),
        .SEC_ONES   (sec_ones),
        .DIGIT_CNT  (digit_cnt),
        .KEY_STROBE (key_strobe),
        .ERR        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int n_err = 0;

    // Reference model state: sampled key history, the key being qualified and
    // how long it has been stable, and the list of entered digits.
    logic [9:0] m_s1 = '0, m_s2 = '0, m_cand = '0;
    int  m_run = 0;
    bit  m_fire = 0, m_release = 0, m_strobe = 0, m_err = 0;
    int  m_digits[$];

    function automatic int onehot_index(input logic [9:0] v);
        int idx = 0;
        for (int i = 0; i < 10; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic model_step();
        logic [9:0] s;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_cand = '0; m_run = 0;
            m_fire = 0; m_release = 0; m_strobe = 0; m_err = 0;
            m_digits.delete();
            return;
        end
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = keys;
        m_strobe = 0;
        m_err = 0;
        if (m_fire) begin
            m_fire = 0;
            m_release = 1;
            m_run = 0;
            if ($countones(m_cand) != 1) m_err = (ERR_EN != 0);
            else if (!clear && m_digits.size() < 4) begin
                m_digits.push_back(onehot_index(m_cand));
                m_strobe = 1;
            end
        end else if (m_release) begin
            m_run = (s == '0) ? m_run + 1 : 0;
            if (m_run == N) begin
                m_release = 0;
                m_run = 0;
            end
        end else if (m_run > 0) begin
            if (s == m_cand) begin
                m_run++;
                if (m_run == N) begin
                    m_fire = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (s != '0 && !lock) begin
            m_cand = s;
            m_run = 1;
        end
        if (clear) m_digits.delete();
    endtask

    function automatic logic [31:0] model_vec();
        logic [15:0] d = '0;
        int sz = m_digits.size();
        for (int k = 0; k < sz; k++) d[4*k +: 4] = 4'(m_digits[sz-1-k]);
        return {11'd0, d, 3'(sz), m_strobe, m_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (key_strobe) n_strobe++;
        if (err) n_err++;
        check("model", {11'd0, min_tens, min_ones, sec_tens, sec_ones, digit_cnt, key_strobe, err},
              model_vec());
    endtask

    task automatic hold(input logic [9:0] k, input logic l, input logic c, input int cyc);
        keys = k; lock = l; clear = c;
        for (int i = 0; i < cyc; i++) tick();
    endtask

    typedef struct {
        logic [9:0]  keys;
        logic        lock;
        logic        clear;
        int          cyc;
        logic [15:0] digits;
        int          cnt;
        int          strobes;
        int          errs;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int s0, e0, found;

        tbl[0]  = '{10'h000, 1'b0, 1'b1,  1, 16'h0000, 0, 0, 0};
        tbl[1]  = '{10'h002, 1'b0, 1'b0, 10, 16'h0001, 1, 1, 0};
        tbl[2]  = '{10'h000, 1'b0, 1'b0, 10, 16'h0001, 1, 0, 0};
        tbl[3]  = '{10'h004, 1'b0, 1'b0, 10, 16'h0012, 2, 1, 0};
        tbl[4]  = '{10'h000, 1'b0, 1'b0, 10, 16'h0012, 2, 0, 0};
        tbl[5]  = '{10'h008, 1'b0, 1'b0, 10, 16'h0123, 3, 1, 0};
        tbl[6]  = '{10'h000, 1'b0, 1'b0, 10, 16'h0123, 3, 0, 0};
        tbl[7]  = '{10'h001, 1'b0, 1'b0, 10, 16'h1230, 4, 1, 0};
        tbl[8]  = '{10'h000, 1'b0, 1'b0, 10, 16'h1230, 4, 0, 0};
        tbl[9]  = '{10'h200, 1'b0, 1'b0, 10, 16'h1230, 4, 0, 0};
        tbl[10] = '{10'h000, 1'b0, 1'b0, 10, 16'h1230, 4, 0, 0};
        tbl[11] = '{10'h021, 1'b0, 1'b0, 10, 16'h1230, 4, 0, ERR_EN};
        tbl[12] = '{10'h000, 1'b0, 1'b0, 10, 16'h1230, 4, 0, 0};
        tbl[13] = '{10'h000, 1'b0, 1'b1,  1, 16'h0000, 0, 0, 0};
        tbl[14] = '{10'h021, 1'b0, 1'b0, 10, 16'h0000, 0, 0, ERR_EN};
        tbl[15] = '{10'h000, 1'b0, 1'b0, 10, 16'h0000, 0, 0, 0};
        tbl[16] = '{10'h080, 1'b1, 1'b0, 10, 16'h0000, 0, 0, 0};
        tbl[17] = '{10'h000, 1'b1, 1'b0, 10, 16'h0000, 0, 0, 0};

        // Reset held with key 2 down, then the key is taken as a fresh press.
        rst = 1'b1; keys = 10'h004; lock = 1'b0; clear = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("reset digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0);
        check("reset count", digit_cnt, 32'd0);
        check("reset strobe", key_strobe, 32'd0);
        rst = 1'b0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (key_strobe && found == 0) found = i;
        end
        check("first strobe latency", found, 32'd7);
        check("post-reset press digit", sec_ones, 32'd2);
        check("post-reset press count", digit_cnt, 32'd1);
        hold(10'h000, 1'b0, 1'b0, 10);

        for (int i = 0; i < 18; i++) begin
            s0 = n_strobe;
            e0 = n_err;
            hold(tbl[i].keys, tbl[i].lock, tbl[i].clear, tbl[i].cyc);
            check($sformatf("vec%0d digits", i), {min_tens, min_ones, sec_tens, sec_ones}, tbl[i].digits);
            check($sformatf("vec%0d count", i), digit_cnt, tbl[i].cnt);
            check($sformatf("vec%0d strobes", i), n_strobe - s0, tbl[i].strobes);
            check($sformatf("vec%0d errs", i), n_err - e0, tbl[i].errs);
        end

        // Bouncing key 5, then a long hold: exactly one capture.
        s0 = n_strobe;
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 10'h020 : 10'h000, 1'b0, 1'b0, 2);
        hold(10'h020, 1'b0, 1'b0, 100);
        check("bounce strobes", n_strobe - s0, 32'd1);
        check("bounce digit", sec_ones, 32'd5);
        check("bounce count", digit_cnt, 32'd1);
        hold(10'h000, 1'b0, 1'b0, 10);

        // LOCK rising once the press is already being qualified.
        s0 = n_strobe;
        hold(10'h080, 1'b0, 1'b0, 3);
        hold(10'h080, 1'b1, 1'b0, 7);
        hold(10'h000, 1'b1, 1'b0, 10);
        check("late lock strobes", n_strobe - s0, 32'd1);
        check("late lock digits", {sec_tens, sec_ones}, 32'h57);
        lock = 1'b0;

        // CLEAR landing on the capture cycle of a third press.
        hold(10'h000, 1'b0, 1'b1, 1);
        hold(10'h010, 1'b0, 1'b0, 10);
        hold(10'h000, 1'b0, 1'b0, 10);
        hold(10'h004, 1'b0, 1'b0, 10);
        hold(10'h000, 1'b0, 1'b0, 10);
        check("pre-clear digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0042);
        s0 = n_strobe;
        hold(10'h002, 1'b0, 1'b0, 6);
        hold(10'h002, 1'b0, 1'b1, 1);
        hold(10'h002, 1'b0, 1'b0, 3);
        hold(10'h000, 1'b0, 1'b0, 10);
        check("clear-capture strobes", n_strobe - s0, 32'd0);
        check("clear-capture digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0);
        check("clear-capture count", digit_cnt, 32'd0);
        hold(10'h100, 1'b0, 1'b0, 10);
        hold(10'h000, 1'b0, 1'b0, 10);
        check("after clear digit", sec_ones, 32'd8);
        check("after clear count", digit_cnt, 32'd1);

        // Random segments: single keys, multi-key chords, idle gaps, LOCK,
        // CLEAR and occasional reset, all checked by the per-cycle model.
        for (int seg = 0; seg < 260; seg++) begin
            int r;
            int len;
            logic [9:0] k;
            r = int'($urandom_range(0, 99));
            if (r < 60) k = 10'(1) << $urandom_range(0, 9);
            else if (r < 75) k = 10'($urandom) | 10'h001;
            else k = '0;
            keys  = k;
            lock  = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            len   = int'($urandom_range(1, 14));
            tick();
            clear = 1'b0;
            rst   = 1'b0;
            for (int j = 1; j < len; j++) tick();
        end
        hold(10'h000, 1'b0, 1'b0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
